// File: rtl/stddff_pkg.sv
// Shared types and constants for the StdDFF skid-slice family.
package stddff_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/dff_skid_slice_ctrl.sv
// Occupancy FSM for the skid slice: state register, load enables and the
// registered ready/valid decode.
module dff_skid_slice_ctrl
  import stddff_pkg::*;
(
  input  logic CLK,
  input  logic RSTN,
  input  logic in_valid,
  input  logic out_ready,
  output logic main_en,
  output logic skid_en,
  output logic main_sel_skid,
  output logic in_ready,
  output logic out_valid
);

  skid_state_e state_q, state_d;
  // Holds IN_READY low until the first edge after reset release.
  logic        armed_q;
  logic        in_fire;
  logic        out_fire;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= EMPTY;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = armed_q & (state_q != FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    main_en       = 1'b0;
    skid_en       = 1'b0;
    main_sel_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_en = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          state_d = FULL;
          skid_en = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d       = ONE;
          main_en       = 1'b1;
          main_sel_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/dff_skid_slice.sv
// Two-entry ready/valid register slice with registered IN_READY and OUT_*.
// Optional simulation checker enabled by defining STDDFF_SKID_CHECK_EN.
module dff_skid_slice
  import stddff_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [Width-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [Width-1:0] OUT_DATA
);

  logic             main_en;
  logic             skid_en;
  logic             main_sel_skid;
  logic [Width-1:0] main_q;
  logic [Width-1:0] main_d;
  logic [Width-1:0] skid_q;

  dff_skid_slice_ctrl u_ctrl (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .in_valid      (IN_VALID),
    .out_ready     (OUT_READY),
    .main_en       (main_en),
    .skid_en       (skid_en),
    .main_sel_skid (main_sel_skid),
    .in_ready      (IN_READY),
    .out_valid     (OUT_VALID)
  );

  assign main_d = main_sel_skid ? skid_q : IN_DATA;

  // Payload flops carry no reset; OUT_VALID qualifies them.
  always_ff @(posedge CLK) begin
    if (main_en) begin
      main_q <= main_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (skid_en) begin
      skid_q <= IN_DATA;
    end
  end

  assign OUT_DATA = main_q;

`ifdef STDDFF_SKID_CHECK_EN
  logic             rst_seen_q;
  logic             stall_q;
  logic [Width-1:0] stall_data_q;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rst_seen_q <= 1'b1;
      stall_q    <= 1'b0;
    end else begin
      stall_q    <= IN_VALID & ~IN_READY;
    end
  end

  always @(posedge CLK) begin
    stall_data_q <= IN_DATA;
  end

  always @(posedge CLK) begin
    if (rst_seen_q) begin
      a_rstn_known: assert (!$isunknown(RSTN));
    end
    if (RSTN === 1'b1) begin
      a_ctrl_known: assert (!$isunknown({IN_VALID, OUT_READY}));
      if (IN_VALID && IN_READY) begin
        a_in_data_known: assert (!$isunknown(IN_DATA));
      end
      if (OUT_VALID) begin
        a_out_data_known: assert (!$isunknown(OUT_DATA));
      end
      if (stall_q) begin
        a_no_drop: assert (IN_VALID && (IN_DATA == stall_data_q));
      end
    end
  end
`else
  // Default build carries no checker logic.
`endif

endmodule

// File: tb/tb_dff_skid_slice.sv
// Randomized and directed bench for dff_skid_slice against a queue-based
// FIFO model of the slice.
module tb_dff_skid_slice;
  import stddff_pkg::*;

  localparam int unsigned Width = 8;

  logic             CLK;
  logic             RSTN;
  logic             IN_VALID;
  logic             IN_READY;
  logic [Width-1:0] IN_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [Width-1:0] OUT_DATA;

  dff_skid_slice #(.Width(Width)) u_dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int unsigned      n_vec = 0;
  int unsigned      n_err = 0;
  logic [Width-1:0] exp_q[$];
  bit               armed = 1'b0;
  bit               hold = 1'b0;
  bit               seq_mode = 1'b0;
  int unsigned      acc_cnt = 0;
  logic [Width-1:0] nxt = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("out_valid", {31'b0, OUT_VALID}, {31'b0, exp_q.size() > 0});
    check_eq("in_ready", {31'b0, IN_READY},
             {31'b0, armed && (exp_q.size() < int'(SKID_DEPTH))});
    if (exp_q.size() > 0) begin
      check_eq("out_data", {24'b0, OUT_DATA}, {24'b0, exp_q[0]});
    end
  endtask

  // One clock: drive inputs (honouring the no-drop rule), advance model, compare.
  task automatic step(input bit want_valid, input bit ordy);
    bit in_fire;
    bit out_fire;
    OUT_READY = ordy;
    if (!hold) begin
      IN_VALID = want_valid;
      IN_DATA  = nxt;
    end
    in_fire  = IN_VALID && armed && (exp_q.size() < int'(SKID_DEPTH));
    out_fire = (exp_q.size() > 0) && OUT_READY;
    @(posedge CLK);
    if (out_fire) void'(exp_q.pop_front());
    if (in_fire) begin
      exp_q.push_back(IN_DATA);
      acc_cnt++;
      nxt = seq_mode ? nxt + 8'd1 : Width'($urandom);
    end
    armed = 1'b1;
    hold  = IN_VALID && !in_fire;
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    IN_VALID = 1'b0;
    hold     = 1'b0;
    RSTN     = 1'b0;
    #1;
    exp_q.delete();
    armed = 1'b0;
    compare_all();
    repeat (3) @(posedge CLK);
    #1;
    compare_all();
    #3 RSTN = 1'b1;
    #1;
    compare_all();
  endtask

  initial begin
    RSTN      = 1'b1;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    OUT_READY = 1'b0;
    #2;
    pulse_reset();

    // Single beat.
    seq_mode = 1'b0;
    nxt = 8'hA5;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Back-to-back stream 0..15.
    seq_mode = 1'b1;
    nxt = 8'h00;
    repeat (16) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);

    // Backpressure: 0..7 with a 4-cycle output stall after beat 2.
    nxt = 8'h00;
    acc_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(acc_cnt < 8, !(i >= 3 && i <= 6));
    end
    check_eq("bp_count", acc_cnt, 32'd8);

    // Reset with the slice full.
    seq_mode = 1'b0;
    nxt = 8'h11;
    step(1'b1, 1'b0);
    nxt = 8'h22;
    step(1'b1, 1'b0);
    check_eq("full_depth", exp_q.size(), 32'd2);
    pulse_reset();
    nxt = 8'h33;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check_eq("post_rst_data", {24'b0, OUT_DATA}, 32'h33);
    step(1'b0, 1'b1);

    // Random soak.
    nxt = Width'($urandom);
    repeat (10000) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    repeat (4) step(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
